// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state encoding and field widths for the I2C transaction arbiter.
package i2c_arb_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/i2c_rr_pick.sv
// i2c_rr_pick: combinational round-robin picker, first set request at/after ptr with wrap.
module i2c_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  always_comb begin
    idx = '0;
    j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i - ((int'(ptr) + i >= N) ? N : 0);
      if (req[j[IW-1:0]]) idx = j[IW-1:0];
    end
  end
  assign any = |req;
  assign grant = any ? N'(1) << idx : '0;
endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one I2C byte-write core among NUM_REQ requesters.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_rw,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  output logic                      core_enable,
  output logic [ADDR_W-1:0]         core_addr,
  output logic [DATA_W-1:0]         core_data,
  output logic                      core_rw,
  input  logic                      core_busy,
  input  logic                      core_nack
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, gidx_q, pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic any, fire, to, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic rw_q;
  i2c_rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_valid),
    .ptr  (ptr_q),
    .grant(pick_oh),
    .idx  (pick_idx),
    .any  (any)
  );
  // A core still busy from elsewhere blocks new grants.
  assign fire = !rst && state_q == IDLE && any && !core_busy;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fire ? LAUNCH : IDLE;
      LAUNCH:  state_d = to ? DONE : core_busy ? RUN : LAUNCH;
      RUN:     state_d = (to || !core_busy) ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (fire) cnt_q <= '0;
    else if (core_enable) cnt_q <= cnt_q + 1'b1;
  end
  assign to = core_enable && cnt_q == CW'(TIMEOUT_CYC - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign to = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        gidx_q <= pick_idx;
        addr_q <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        data_q <= req_data[pick_idx*DATA_W +: DATA_W];
        rw_q   <= req_rw[pick_idx];
        err_q  <= 1'b0;
      end else if (to) err_q <= 1'b1;
      else if (state_q == RUN) err_q <= err_q | core_nack;
      if (state_q == DONE) ptr_q <= (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    end
  end
  assign req_ready   = fire ? pick_oh : '0;
  assign rsp_valid   = state_q == DONE ? NUM_REQ'(1) << gidx_q : '0;
  assign rsp_err     = state_q == DONE && err_q;
  assign core_enable = state_q == LAUNCH || state_q == RUN;
  assign core_addr   = addr_q;
  assign core_data   = data_q;
  assign core_rw     = rw_q;
endmodule
